// File: rtl/rat_pkg.sv
// rat_pkg: shared types and constants for the RAT MCU execute stage
package rat_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_CMP, ALU_AND, ALU_OR, ALU_EXOR,
        ALU_TEST, ALU_LSL, ALU_LSR, ALU_ROL, ALU_ROR, ALU_ASR, ALU_MOV, ALU_RSVD
    } alu_op_t;
endpackage

// File: rtl/rat_alu.sv
// rat_alu: combinational 8-bit ALU producing result, carry-out and zero-out
module rat_alu
    import rat_pkg::*;
#(
    parameter int WIDTH = rat_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          sel,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             alu_c,
    output logic             alu_z
);
    // bit WIDTH holds carry/borrow or the shifted-out bit
    logic [WIDTH:0] r;
    always_comb begin
        r = '0;
        case (sel)
            ALU_ADD:          r = {1'b0, a} + {1'b0, b};
            ALU_ADDC:         r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
            ALU_SUB, ALU_CMP: r = {1'b0, a} - {1'b0, b};
            ALU_SUBC:         r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
            ALU_AND, ALU_TEST: r = {1'b0, a & b};
            ALU_OR:           r = {1'b0, a | b};
            ALU_EXOR:         r = {1'b0, a ^ b};
            ALU_LSL:          r = {a, c_in};
            ALU_LSR:          r = {a[0], c_in, a[WIDTH-1:1]};
            ALU_ROL:          r = {a, a[WIDTH-1]};
            ALU_ROR:          r = {a[0], a[0], a[WIDTH-1:1]};
            ALU_ASR:          r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            ALU_MOV:          r = {1'b0, b};
            default:          r = '0;
        endcase
    end
    assign result = r[WIDTH-1:0];
    assign alu_c  = r[WIDTH];
    assign alu_z  = (result == '0);
endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: RAT execute stage with C/Z flags and interrupt shadow flags
module alu_flag_unit
    import rat_pkg::*;
#(
    parameter int WIDTH = rat_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    input  logic             flg_c_ld,
    input  logic             flg_c_set,
    input  logic             flg_c_clr,
    input  logic             flg_z_ld,
    input  logic             flg_ld_sel,
    input  logic             flg_shad_ld,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag
);
    logic alu_c, alu_z, shad_c, shad_z;

    rat_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a),
        .b      (b),
        .sel    (alu_op_t'(alu_sel)),
        .c_in   (c_flag),
        .result (result),
        .alu_c  (alu_c),
        .alu_z  (alu_z)
    );

    // shadow samples pre-edge flags, so a combined save+restore swaps them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {c_flag, z_flag, shad_c, shad_z} <= '0;
        end else begin
            if (flg_c_clr)     c_flag <= 1'b0;
            else if (flg_c_set) c_flag <= 1'b1;
            else if (flg_c_ld)  c_flag <= flg_ld_sel ? shad_c : alu_c;
            if (flg_z_ld)      z_flag <= flg_ld_sel ? shad_z : alu_z;
            if (flg_shad_ld)   {shad_c, shad_z} <= {c_flag, z_flag};
        end
    end
endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Execute stage of the 8-bit RAT MCU datapath: consumes the two register-file read ports (X operand, plus Y operand or an immediate selected upstream) and produces the 8-bit result that the writeback mux returns to the register file. Also holds the architectural C and Z flags and the shadow flags used across interrupts. Result and flag-next values are combinational. Flag state is registered on `clk`.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; only 8 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  8  operand A (register-file X read data).
- `b`  in  8  operand B (register-file Y read data or immediate).
- `alu_sel`  in  4  operation select (`alu_op_t`).
- `flg_c_ld`  in  1  load C from ALU carry-out.
- `flg_c_set`  in  1  force C to 1.
- `flg_c_clr`  in  1  force C to 0.
- `flg_z_ld`  in  1  load Z from ALU zero-out.
- `flg_ld_sel`  in  1  when set, C/Z loads take shadow values instead of ALU outputs.
- `flg_shad_ld`  in  1  copy current C/Z into shadow C/Z.
- `result`  out  8  combinational ALU result.
- `c_flag`  out  1  registered carry flag.
- `z_flag`  out  1  registered zero flag.

## Operation
- Every operation computes a 9-bit internal sum or shift. `alu_c` is bit 8 or the shifted-out bit. `alu_z` = (result[7:0] == 0).
- Operations by `alu_sel` code:
  - 0 ADD: a+b.
  - 1 ADDC: a+b+C.
  - 2 SUB: a−b; `alu_c` = borrow.
  - 3 SUBC: a−b−C; `alu_c` = borrow.
  - 4 CMP: computed as SUB; `result` carries the difference. The upstream control unit does not write it back.
  - 5 AND, 6 OR, 7 EXOR: `alu_c` = 0.
  - 8 TEST: computed as AND; `alu_c` = 0.
  - 9 LSL: {a[6:0],C}; `alu_c` = a[7].
  - 10 LSR: {C,a[7:1]}; `alu_c` = a[0].
  - 11 ROL: {a[6:0],a[7]}; `alu_c` = a[7].
  - 12 ROR: {a[0],a[7:1]}; `alu_c` = a[0].
  - 13 ASR: {a[7],a[7:1]}; `alu_c` = a[0].
  - 14 MOV: result = b; `alu_c` = 0.
  - 15 reserved: result = 0, `alu_c` = 0.
- "C" in the operations above means the current registered `c_flag`, never the next value.
- Next-C priority:
  1. `flg_c_clr` → 0.
  2. `flg_c_set` → 1.
  3. `flg_c_ld` → (`flg_ld_sel` ? shadow C : `alu_c`).
  4. Otherwise hold.
- Next-Z: if `flg_z_ld`, (`flg_ld_sel` ? shadow Z : `alu_z`); otherwise hold.
- Shadow: on `flg_shad_ld`, shadow C/Z ← the current registered C/Z, i.e. the pre-edge values.
- Simultaneous `flg_shad_ld` with `flg_c_ld`/`flg_z_ld`:
  - Shadow captures the old flags.
  - Flags take their new values.
  - If `flg_ld_sel` is also set, flags take the old shadow values. Flags and shadow then swap.

## Timing
- `result` is valid combinationally in the same cycle as `a`, `b`, `alu_sel`. No internal latency.
- Flag updates take effect at the rising `clk` edge that samples the control strobes. The new value is visible to the next instruction.
- ADDC/SUBC/shift ops in cycle N use C as registered at the end of cycle N−1.
- Reset: `c_flag` = 0, `z_flag` = 0, shadow C = 0, shadow Z = 0 asynchronously on `rst_n` low.
- `result` is not reset; it follows its inputs.
- Reset asserted mid-instruction discards any pending flag load. Flags stay 0 until the first edge after `rst_n` rises.

## Structure
- Shared package `rat_pkg`:
  - `alu_op_t` (4-bit enum of the 16 codes above).
  - `WIDTH` constant default.
- Sub-module `rat_alu`: purely combinational. Inputs a, b, sel, c_in; outputs result, alu_c, alu_z.
- `alu_flag_unit` instantiates `rat_alu` and contains the flag, shadow and priority logic in one `always_ff` with async reset.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle → `c_flag`=0 and `z_flag`=0 immediately. Then ADD a=0xFF, b=0x01 with `flg_c_ld`=`flg_z_ld`=1 → `result`=0x00; after the edge C=1, Z=1.
- Carry chain: C=1, ADDC a=0x10, b=0x20 → `result`=0x31. SUBC a=0x00, b=0x00 with C=1 → `result`=0xFF, borrow → C=1, Z=0.
- Shifts with C=1, a=0x81:
  - LSL → 0x03, C=1.
  - LSR → 0xC0, C=1.
  - ROR → 0xC0, C=1.
  - ASR → 0xC0, C=1.
  - ROL → 0x03, C=1.
- Flag priority: `flg_c_clr`=`flg_c_set`=`flg_c_ld`=1 with `alu_c`=1 → C=0. `flg_c_set`+`flg_c_ld` with `alu_c`=0 → C=1.
- Interrupt save/restore sequence:
  1. With C=1, Z=0, pulse `flg_shad_ld`.
  2. CMP a=5, b=5 with loads → C=0, Z=1.
  3. Pulse `flg_ld_sel`+`flg_c_ld`+`flg_z_ld` → C=1, Z=0.
- Swap: C=1, Z=1, shadow C=0, Z=0. Assert `flg_shad_ld`+`flg_ld_sel`+`flg_c_ld`+`flg_z_ld` → flags C=0, Z=0; shadow C=1, Z=1.
